// File: rtl/key_debounce_pkg.sv
`default_nettype none
// ============================================================================
// key_debounce_pkg : state encodings and timing defaults for key_debounce
// Revision 1.0
// ============================================================================
package key_debounce_pkg;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } state_t;

    // Board timing assumes ADC_CLK_10: 5 ms debounce, 1 s long press.
    localparam int BOARD_STABLE_COUNT = 50000;
    localparam int BOARD_HOLD_COUNT   = 10000000;
    localparam int SIM_STABLE_COUNT   = 4;
    localparam int SIM_HOLD_COUNT     = 10;
    localparam int DEFAULT_CNT_W      = 24;

endpackage : key_debounce_pkg
`default_nettype wire

// File: rtl/key_debounce_channel.sv
`default_nettype none
// ============================================================================
// key_debounce_channel : one key - 2-flop synchroniser, debounce FSM, strobes
// Revision 1.0
// ============================================================================
module key_debounce_channel
    import key_debounce_pkg::*;
#(
    parameter int STABLE_COUNT = BOARD_STABLE_COUNT,
    parameter int HOLD_COUNT   = BOARD_HOLD_COUNT,
    parameter int CNT_W        = DEFAULT_CNT_W
) (
    input  logic clock,
    input  logic reset,
    input  logic key_n,
    output logic key_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_press
);

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(STABLE_COUNT - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_COUNT - 1);
    localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(HOLD_COUNT);

    logic             sync1;
    logic             sync2;
    logic             pressed_s;
    state_t           state;
    logic [CNT_W-1:0] deb_cnt;
    logic [CNT_W-1:0] hold_cnt;

    // Synchroniser resets to "released" so a power-up edge is not seen as a press.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
        end
    end

    assign pressed_s = ~sync2;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            deb_cnt       <= '0;
            hold_cnt      <= '0;
            key_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_press    <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_press    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pressed_s) begin
                        state   <= ST_PRESS_WAIT;
                        deb_cnt <= CNT_W'(1);
                    end
                end
                // A bounce is checked before the accept compare so the two never coincide.
                ST_PRESS_WAIT: begin
                    if (!pressed_s) begin
                        state   <= ST_IDLE;
                        deb_cnt <= '0;
                    end else if (deb_cnt == DEB_LAST) begin
                        state       <= ST_PRESSED;
                        press_pulse <= 1'b1;
                        key_level   <= 1'b1;
                        hold_cnt    <= '0;
                    end else begin
                        deb_cnt <= deb_cnt + CNT_W'(1);
                    end
                end
                ST_PRESSED: begin
                    if (!pressed_s) begin
                        state   <= ST_RELEASE_WAIT;
                        deb_cnt <= CNT_W'(1);
                    end else if (hold_cnt != HOLD_MAX) begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                        if (hold_cnt == HOLD_LAST) begin
                            long_press <= 1'b1;
                        end
                    end
                end
                // hold_cnt is frozen here and resumes if the release turns out to be a bounce.
                ST_RELEASE_WAIT: begin
                    if (pressed_s) begin
                        state   <= ST_PRESSED;
                        deb_cnt <= '0;
                    end else if (deb_cnt == DEB_LAST) begin
                        state         <= ST_IDLE;
                        release_pulse <= 1'b1;
                        key_level     <= 1'b0;
                    end else begin
                        deb_cnt <= deb_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : key_debounce_channel
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
// key_debounce : per-key synchronise, debounce, press/release/long-press strobes
// Revision 1.0
// ============================================================================
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int WIDTH        = 2,
    parameter int STABLE_COUNT = BOARD_STABLE_COUNT,
    parameter int HOLD_COUNT   = BOARD_HOLD_COUNT,
    parameter int CNT_W        = DEFAULT_CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] key_n,
    output logic [WIDTH-1:0] key_level,
    output logic [WIDTH-1:0] press_pulse,
    output logic [WIDTH-1:0] release_pulse,
    output logic [WIDTH-1:0] long_press
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        key_debounce_channel #(
            .STABLE_COUNT (STABLE_COUNT),
            .HOLD_COUNT   (HOLD_COUNT),
            .CNT_W        (CNT_W)
        ) u_chan (
            .clock         (clock),
            .reset         (reset),
            .key_n         (key_n[i]),
            .key_level     (key_level[i]),
            .press_pulse   (press_pulse[i]),
            .release_pulse (release_pulse[i]),
            .long_press    (long_press[i])
        );
    end

endmodule : key_debounce
`default_nettype wire

// File: tb/tb_key_debounce.sv
`default_nettype none
// ============================================================================
// tb_key_debounce : scoreboard bench - expected strobes queued at stimulus time
// Revision 1.0
// ============================================================================
module tb_key_debounce;

    localparam int W   = 2;
    localparam int SC  = 4;
    localparam int HC  = 10;
    localparam int CW  = 24;
    localparam int LAT = SC + 2;

    typedef enum int {EV_PRESS, EV_RELEASE, EV_LONG} ev_kind_t;
    typedef struct {
        int       cyc;
        ev_kind_t kind;
        int       ch;
    } ev_t;

    logic         clock = 1'b0;
    logic         reset;
    logic [W-1:0] key_n;
    logic [W-1:0] key_level;
    logic [W-1:0] press_pulse;
    logic [W-1:0] release_pulse;
    logic [W-1:0] long_press;

    ev_t          sbq[$];
    int           cyc       = 0;
    int           n_checks  = 0;
    int           n_fail    = 0;
    logic [W-1:0] exp_level = '0;
    int           d;

    always #5 clock = ~clock;

    key_debounce #(
        .WIDTH        (W),
        .STABLE_COUNT (SC),
        .HOLD_COUNT   (HC),
        .CNT_W        (CW)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .key_n         (key_n),
        .key_level     (key_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_press    (long_press)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: cycle %0d got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic expect_ev(input ev_kind_t kind, input int ch, input int at);
        ev_t e;
        e.cyc  = at;
        e.kind = kind;
        e.ch   = ch;
        sbq.push_back(e);
    endtask

    // Advance n cycles; after each edge pop the strobes due now and compare everything.
    task automatic tick(input int n);
        logic [W-1:0] ep;
        logic [W-1:0] er;
        logic [W-1:0] el;
        for (int t = 0; t < n; t++) begin
            @(negedge clock);
            cyc++;
            ep = '0;
            er = '0;
            el = '0;
            for (int i = sbq.size() - 1; i >= 0; i--) begin
                if (sbq[i].cyc == cyc) begin
                    case (sbq[i].kind)
                        EV_PRESS:   ep[sbq[i].ch] = 1'b1;
                        EV_RELEASE: er[sbq[i].ch] = 1'b1;
                        default:    el[sbq[i].ch] = 1'b1;
                    endcase
                    sbq.delete(i);
                end
            end
            exp_level = (exp_level | ep) & ~er;
            check("press_pulse",   32'(press_pulse),   32'(ep));
            check("release_pulse", 32'(release_pulse), 32'(er));
            check("long_press",    32'(long_press),    32'(el));
            check("key_level",     32'(key_level),     32'(exp_level));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_level"},   32'(key_level),     32'd0);
        check({tag, "_press"},   32'(press_pulse),   32'd0);
        check({tag, "_release"}, 32'(release_pulse), 32'd0);
        check({tag, "_long"},    32'(long_press),    32'd0);
    endtask

    initial begin
        reset = 1'b0;
        key_n = 2'b11;
        #1 reset = 1'b1;
        #1 check_all_zero("rst");
        tick(3);
        #2 reset = 1'b0;
        tick(20);

        // Clean press on key 0 held long enough for a single long press, then release.
        d = cyc;
        key_n[0] = 1'b0;
        expect_ev(EV_PRESS, 0, d + LAT);
        expect_ev(EV_LONG,  0, d + LAT + HC);
        tick(30);
        key_n[0] = 1'b1;
        expect_ev(EV_RELEASE, 0, cyc + LAT);
        tick(12);

        // Press bounce: low 2, high 1, low 2, high.
        key_n[0] = 1'b0;
        tick(2);
        key_n[0] = 1'b1;
        tick(1);
        key_n[0] = 1'b0;
        tick(2);
        key_n[0] = 1'b1;
        tick(12);

        // Glitch one cycle short of acceptance: bounce must win over accept.
        key_n[0] = 1'b0;
        tick(SC - 1);
        key_n[0] = 1'b1;
        tick(12);

        // Shortest accepted press.
        d = cyc;
        key_n[0] = 1'b0;
        expect_ev(EV_PRESS, 0, d + LAT);
        tick(SC);
        key_n[0] = 1'b1;
        expect_ev(EV_RELEASE, 0, cyc + LAT);
        tick(12);

        // Release bounce on key 0 (long press delayed 3 cycles), short press on key 1.
        d = cyc;
        key_n[0] = 1'b0;
        expect_ev(EV_PRESS, 0, d + LAT);
        expect_ev(EV_LONG,  0, d + LAT + HC + 3);
        tick(3);
        key_n[1] = 1'b0;
        expect_ev(EV_PRESS, 1, d + 3 + LAT);
        tick(5);
        key_n[0] = 1'b1;
        tick(2);
        key_n[0] = 1'b0;
        tick(2);
        key_n[1] = 1'b1;
        expect_ev(EV_RELEASE, 1, cyc + LAT);
        tick(18);
        key_n[0] = 1'b1;
        expect_ev(EV_RELEASE, 0, cyc + LAT);
        tick(12);

        // Reset while both keys are pressed, then release reset with keys still held.
        d = cyc;
        key_n = 2'b00;
        expect_ev(EV_PRESS, 0, d + LAT);
        expect_ev(EV_PRESS, 1, d + LAT);
        tick(8);
        #2 reset = 1'b1;
        #1 check_all_zero("mid_rst");
        sbq.delete();
        exp_level = '0;
        tick(2);
        #2 reset = 1'b0;
        expect_ev(EV_PRESS, 0, cyc + LAT);
        expect_ev(EV_PRESS, 1, cyc + LAT);
        tick(10);
        key_n = 2'b11;
        expect_ev(EV_RELEASE, 0, cyc + LAT);
        expect_ev(EV_RELEASE, 1, cyc + LAT);
        tick(12);

        check("sb_empty", 32'(sbq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_key_debounce
`default_nettype wire
